// File: rtl/mips_cpu_pc_sequencer.sv
// ---------------------------------------------------------------------------
// mips_cpu_pc_sequencer
//   Program-counter and instruction-phase sequencer for the multi-cycle MIPS
//   core. Steps each instruction through FETCH -> EXEC1 -> EXEC2. It drives
//   the instruction-memory read handshake and the exec1/exec2 phase strobes.
//   At retire it picks the next PC from the delay-slot register or pc + 4.
//   It halts when the next PC equals HALT_ADDR.
//
// Build option:
//   MIPS_PC_ALIGN_CHECK_EN  defined   : adds output align_fault. A misaligned
//                                       next PC loads pc, halts and sets the
//                                       sticky align_fault flag.
//                           undefined : next_pc[1:0] is forced to 2'b00
//                                       before it is loaded into pc.
//
// Ports:
//   clk                in   system clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   instr_waitrequest  in   instruction memory busy (sampled in FETCH only)
//   stall              in   data-memory stall (sampled in EXEC2 only)
//   delay_address[31:0]in   branch/jump target from the delay-slot register
//   delay_ctrl         in   take delay_address at this retire (EXEC2 only)
//   instr_read         out  instruction read request (high in FETCH)
//   instr_address[31:0]out  fetch address, always equal to pc
//   pc[31:0]           out  current instruction PC
//   pc_plus4[31:0]     out  pc + 4, modulo 2^32
//   exec1              out  one-cycle phase-1 strobe per instruction
//   exec2              out  phase-2 strobe, high for the whole EXEC2 phase
//   active             out  high while the core is running
//   retire             out  one-cycle pulse in the cycle the new PC appears
//   align_fault        out  sticky misaligned-target flag (option only)
// ---------------------------------------------------------------------------
module mips_cpu_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_waitrequest,
  input  logic        stall,
  input  logic [31:0] delay_address,
  input  logic        delay_ctrl,
  output logic        instr_read,
  output logic [31:0] instr_address,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exec1,
  output logic        exec2,
  output logic        active,
  output logic        retire
`ifdef MIPS_PC_ALIGN_CHECK_EN
  ,
  output logic        align_fault
`endif
);

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC1    = 3'd2,
    ST_EXEC2    = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [ADDR_W-1:0]   pc_plus4_nxt;
  logic [ADDR_W-1:0]   target_c;
  logic                commit_c;
  logic                instr_read_nxt;
  logic                exec1_nxt;
  logic                exec2_nxt;
  logic                active_nxt;
`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic                misaligned_c;
  logic                align_fault_nxt;
`endif

  // The fetch address is the PC register itself.
  assign instr_address = pc;

  // Next-state, next-PC and next-strobe decode.
  always_comb begin
    state_nxt    = state_q;
    pc_nxt       = pc;
    pc_plus4_nxt = pc_plus4;
    commit_c     = 1'b0;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    target_c        = delay_ctrl ? delay_address : pc_plus4;
    misaligned_c    = (target_c[1:0] != 2'b00);
    align_fault_nxt = align_fault;
`else
    // Word alignment is enforced by dropping the low address bits.
    target_c = (delay_ctrl ? delay_address : pc_plus4) & ALIGN_MASK;
`endif

    unique case (state_q)
      ST_RST_WAIT: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!instr_waitrequest) state_nxt = ST_EXEC1;
      end
      ST_EXEC1: state_nxt = ST_EXEC2;
      ST_EXEC2: begin
        if (!stall) begin
          commit_c     = 1'b1;
          pc_nxt       = target_c;
          pc_plus4_nxt = target_c + PC_STEP;
`ifdef MIPS_PC_ALIGN_CHECK_EN
          if (misaligned_c) begin
            align_fault_nxt = 1'b1;
            state_nxt       = ST_HALT;
          end else if (target_c == HALT_ADDR) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_FETCH;
          end
`else
          state_nxt = (target_c == HALT_ADDR) ? ST_HALT : ST_FETCH;
`endif
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RST_WAIT;
    endcase

    // Strobes are decoded from the next state so that each one comes
    // straight out of its own flop.
    instr_read_nxt = (state_nxt == ST_FETCH);
    exec1_nxt      = (state_nxt == ST_EXEC1);
    exec2_nxt      = (state_nxt == ST_EXEC2);
    active_nxt     = (state_nxt == ST_FETCH) || (state_nxt == ST_EXEC1) ||
                     (state_nxt == ST_EXEC2);
  end

  // State, PC and registered strobes. Reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RST_WAIT;
      pc         <= RESET_VECTOR;
      pc_plus4   <= RESET_VECTOR + PC_STEP;
      instr_read <= 1'b0;
      exec1      <= 1'b0;
      exec2      <= 1'b0;
      active     <= 1'b0;
      retire     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pc         <= pc_nxt;
      pc_plus4   <= pc_plus4_nxt;
      instr_read <= instr_read_nxt;
      exec1      <= exec1_nxt;
      exec2      <= exec2_nxt;
      active     <= active_nxt;
      retire     <= commit_c;
    end
  end

`ifdef MIPS_PC_ALIGN_CHECK_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      align_fault <= 1'b0;
    end else begin
      align_fault <= align_fault_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mips_cpu_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_pc_sequencer
//   Directed bench for mips_cpu_pc_sequencer. Expected fetch addresses are
//   queued when the stimulus that causes them is driven. They are popped on
//   each rising instr_read. Strobes and pc are checked cycle by cycle at the
//   falling clock edge. Covers MIPS_PC_ALIGN_CHECK_EN either way.
// ---------------------------------------------------------------------------
module tb_mips_cpu_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        instr_waitrequest;
  logic        stall;
  logic [31:0] delay_address;
  logic        delay_ctrl;
  logic        instr_read;
  logic [31:0] instr_address;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec1;
  logic        exec2;
  logic        active;
  logic        retire;
`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] exp_fetch_q[$];
  logic        rd_prev = 1'b0;

  mips_cpu_pc_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .instr_waitrequest (instr_waitrequest),
    .stall             (stall),
    .delay_address     (delay_address),
    .delay_ctrl        (delay_ctrl),
    .instr_read        (instr_read),
    .instr_address     (instr_address),
    .pc                (pc),
    .pc_plus4          (pc_plus4),
    .exec1             (exec1),
    .exec2             (exec2),
    .active            (active),
    .retire            (retire)
`ifdef MIPS_PC_ALIGN_CHECK_EN
    ,
    .align_fault       (align_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {instr_read, exec1, exec2, retire, active}.
  task automatic st(input string tag, input logic [4:0] e);
    chk(tag, 32'({instr_read, exec1, exec2, retire, active}), 32'(e));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Scoreboard: each new fetch must match the oldest queued address.
  always @(negedge clk) begin
    if (instr_read && !rd_prev) begin
      if (exp_fetch_q.size() == 0) chk("unexpected_fetch", 32'(exp_fetch_q.size()), 32'd1);
      else chk("fetch_addr", instr_address, exp_fetch_q.pop_front());
    end
    rd_prev <= instr_read;
  end

  initial begin
    reset_n           = 1'b0;
    instr_waitrequest = 1'b0;
    stall             = 1'b0;
    delay_address     = 32'h0;
    delay_ctrl        = 1'b0;
    cyc(); cyc();
    st("reset_strobes", 5'b00000);
    chk("reset_pc", pc, 32'hBFC00000);
    chk("reset_pc_plus4", pc_plus4, 32'hBFC00004);
`ifdef MIPS_PC_ALIGN_CHECK_EN
    chk("reset_align_fault", 32'(align_fault), 32'd0);
`endif

    // Straight-line execution from the reset vector.
    exp_fetch_q.push_back(32'hBFC00000);
    exp_fetch_q.push_back(32'hBFC00004);
    exp_fetch_q.push_back(32'hBFC00008);
    reset_n = 1'b1;
    cyc(); st("c1_fetch", 5'b10001); chk("c1_addr", instr_address, 32'hBFC00000);
    cyc(); st("c2_exec1", 5'b01001);
    cyc(); st("c3_exec2", 5'b00101);
    cyc(); st("c4_fetch", 5'b10011); chk("c4_pc", pc, 32'hBFC00004);
    cyc(); st("c5_exec1", 5'b01001);
    cyc(); st("c6_exec2", 5'b00101);
    cyc(); st("c7_fetch", 5'b10011); chk("c7_pc", pc, 32'hBFC00008);
    cyc(); st("c8_exec1", 5'b01001);
    // Delay slot taken; raised during EXEC1, where it must be ignored.
    delay_ctrl    = 1'b1;
    delay_address = 32'hBFC00100;
    exp_fetch_q.push_back(32'hBFC00100);
    cyc(); st("c9_exec2", 5'b00101); chk("c9_pc", pc, 32'hBFC00008);
    cyc(); st("c10_fetch", 5'b10011); chk("c10_pc", pc, 32'hBFC00100);
    delay_ctrl = 1'b0;
    cyc(); st("c11_exec1", 5'b01001);
    cyc(); st("c12_exec2", 5'b00101);
    // Waitrequest raised in EXEC2 is ignored, then holds the next FETCH.
    instr_waitrequest = 1'b1;
    exp_fetch_q.push_back(32'hBFC00104);
    cyc(); st("c13_fetch", 5'b10011); chk("c13_pc", pc, 32'hBFC00104);
    for (int i = 14; i <= 17; i++) begin
      cyc(); st($sformatf("c%0d_wait", i), 5'b10001);
      chk($sformatf("c%0d_pc", i), pc, 32'hBFC00104);
    end
    instr_waitrequest = 1'b0;
    cyc(); st("c18_exec1", 5'b01001);
    stall = 1'b1;
    // Stall sampled at the EXEC1->EXEC2 edge is ignored; EXEC2 holds 4 cycles.
    for (int i = 19; i <= 22; i++) begin
      cyc(); st($sformatf("c%0d_stall", i), 5'b00101);
    end
    stall = 1'b0;
    exp_fetch_q.push_back(32'hBFC00108);
    cyc(); st("c23_fetch", 5'b10011); chk("c23_pc", pc, 32'hBFC00108);
    chk("c23_pc_plus4", pc_plus4, 32'hBFC0010C);
    cyc(); st("c24_exec1", 5'b01001);
    // Jump to address 0 halts.
    delay_ctrl    = 1'b1;
    delay_address = 32'h0;
    cyc(); st("c25_exec2", 5'b00101);
    cyc(); st("c26_halt", 5'b00010); chk("c26_pc", pc, 32'h0);
    delay_ctrl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(); st($sformatf("halt_idle%0d", i), 5'b00000);
    end
    chk("halt_pc_held", pc, 32'h0);

    // Reset asserted mid-EXEC2 with stall high aborts immediately.
    reset_n = 1'b0;
    cyc();
    exp_fetch_q.push_back(32'hBFC00000);
    reset_n = 1'b1;
    cyc(); st("r1_fetch", 5'b10001);
    cyc(); st("r2_exec1", 5'b01001);
    stall = 1'b1;
    cyc(); st("r3_exec2", 5'b00101);
    #2 reset_n = 1'b0;
    #1 st("async_reset_strobes", 5'b00000);
    chk("async_reset_pc", pc, 32'hBFC00000);
    cyc();
    stall = 1'b0;
    exp_fetch_q.push_back(32'hBFC00000);
    reset_n = 1'b1;
    cyc(); st("rr1_fetch", 5'b10001); chk("rr1_pc", pc, 32'hBFC00000);
    cyc(); st("rr2_exec1", 5'b01001);
    delay_ctrl    = 1'b1;
    delay_address = 32'hBFC00102;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    cyc(); st("rr3_exec2", 5'b00101);
    cyc(); st("align_halt", 5'b00010);
    chk("align_fault_set", 32'(align_fault), 32'd1);
    chk("align_pc", pc, 32'hBFC00102);
    delay_ctrl = 1'b0;
    repeat (3) cyc();
    chk("align_fault_sticky", 32'(align_fault), 32'd1);
    st("align_idle", 5'b00000);
`else
    // Misaligned target is forced to a word boundary.
    exp_fetch_q.push_back(32'hBFC00100);
    cyc(); st("rr3_exec2", 5'b00101);
    cyc(); st("rr4_fetch", 5'b10011); chk("forced_pc", pc, 32'hBFC00100);
    cyc(); st("rr5_exec1", 5'b01001);
    // Jump to the last word; the sequential step wraps to 0 and halts.
    delay_address = 32'hFFFFFFFC;
    exp_fetch_q.push_back(32'hFFFFFFFC);
    cyc(); st("rr6_exec2", 5'b00101);
    cyc(); st("rr7_fetch", 5'b10011); chk("top_pc", pc, 32'hFFFFFFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    delay_ctrl = 1'b0;
    cyc(); st("rr8_exec1", 5'b01001);
    cyc(); st("rr9_exec2", 5'b00101);
    cyc(); st("wrap_halt", 5'b00010); chk("wrap_pc", pc, 32'h0);
    repeat (3) cyc();
    st("wrap_idle", 5'b00000);
`endif
    chk("fetch_queue_drained", 32'(exp_fetch_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
